atmega_tim_prescaler: RTL

//  Shared prescaler and GTCCR controller for the ATMEGA timers. Free-runs a 10-bit

---
 rtl/atmega_tim_prescaler.sv | 104 ++++++++++
 1 files changed

// File: rtl/atmega_tim_prescaler.sv
// Shared timer prescaler with GTCCR control (TSM/PSRASY/PSRSYNC) and
// external Tn pin synchronizer producing one-cycle rise/fall pulses.
module atmega_tim_prescaler #(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR        = 'h43
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  output logic                         clk8_o,
  output logic                         clk64_o,
  output logic                         clk256_o,
  output logic                         clk1024_o,
  output logic                         psrasy_o,
  output logic                         tim_halt_o,
  input  logic                         t_i,
  output logic                         t_rise_o,
  output logic                         t_fall_o
);

  logic [9:0] cnt_q, cnt_d;
  logic       tsm_q, tsm_d;
  logic       psrasy_q, psrasy_d;
  logic       psrsync_q, psrsync_d;
  logic       gtccr_sel;
  logic       gtccr_wr;

  logic       s1_q, s2_q, d1_q, d2_q;
  logic       rise_q, fall_q;

  assign gtccr_sel = (addr_i == GTCCR_ADDR);
  assign gtccr_wr  = wr_i && gtccr_sel;

  // A bus write takes priority over the auto-clear at the same edge.
  always_comb begin
    tsm_d     = tsm_q;
    psrasy_d  = psrasy_q;
    psrsync_d = psrsync_q;
    if (gtccr_wr) begin
      tsm_d     = bus_i[7];
      psrasy_d  = bus_i[1];
      psrsync_d = bus_i[0];
    end else if (!tsm_q) begin
      psrasy_d  = 1'b0;
      psrsync_d = 1'b0;
    end
  end

  // Divider sits at 0 while PSRSYNC is set, so it restarts 0->1 after release.
  always_comb begin
    cnt_d = cnt_q + 10'd1;
    if ((gtccr_wr && bus_i[0]) || psrsync_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      tsm_q     <= 1'b0;
      psrasy_q  <= 1'b0;
      psrsync_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tsm_q     <= tsm_d;
      psrasy_q  <= psrasy_d;
      psrsync_q <= psrsync_d;
    end
  end

  // Two-flop synchronizer, one delay stage for edge detect, registered pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      d1_q   <= 1'b0;
      d2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= t_i;
      s2_q   <= s1_q;
      d1_q   <= s2_q;
      d2_q   <= d1_q;
      rise_q <= d1_q & ~d2_q;
      fall_q <= ~d1_q & d2_q;
    end
  end

  assign clk8_o     = cnt_q[2];
  assign clk64_o    = cnt_q[5];
  assign clk256_o   = cnt_q[7];
  assign clk1024_o  = cnt_q[9];
  assign psrasy_o   = psrasy_q;
  assign tim_halt_o = tsm_q & psrsync_q;
  assign t_rise_o   = rise_q;
  assign t_fall_o   = fall_q;
  assign bus_o      = (rd_i && gtccr_sel) ? {tsm_q, 5'b00000, psrasy_q, psrsync_q} : 8'h00;

endmodule
